// File: rtl/usb_rx_crc_check.sv
// USB receive-path CRC checker: serial CRC5/CRC16 residue check on the unstuffed
// post-PID bit stream, with the trailing CRC stripped from the forwarded stream.
//
// state | meaning
// IDLE  | waiting for start; s_valid and endr ignored
// RECV  | consuming bits, updating CRC, forwarding delayed payload
// STAT  | one cycle with done and registered status
module usb_rx_crc_check #(
    parameter int MAX_DATA_BYTES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_in,
    input  logic       s_valid,
    input  logic       start,
    input  logic       endr,
    input  logic [1:0] pkt_type,
    output logic       d_out,
    output logic       d_valid,
    output logic       done,
    output logic       crc_ok,
    output logic       len_err
);

    localparam int CNT_MAX = 8 * MAX_DATA_BYTES + 16;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_SAT = CW'(CNT_MAX);
    localparam logic [CW-1:0] CNT_MIN = CW'(16);
    localparam logic [1:0]    TYPE_DATA  = 2'd0;
    localparam logic [1:0]    TYPE_TOKEN = 2'd1;
    localparam logic [4:0]    POLY5  = 5'b00101;
    localparam logic [15:0]   POLY16 = 16'h8005;
    localparam logic [4:0]    RES5   = 5'b01100;
    localparam logic [15:0]   RES16  = 16'h800D;

    typedef enum logic [1:0] {IDLE, RECV, STAT} state_t;

    state_t        state_q;
    logic [1:0]    type_q;
    logic [4:0]    crc5_q, crc5_d;
    logic [15:0]   crc16_q, crc16_d;
    logic [15:0]   dl_q, dl_d;
    logic [4:0]    fill_q, fill_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          done_q, crc_ok_q, len_err_q;

    logic       is_data, is_tok, take, head, fb5, fb16;
    logic [4:0] depth;
    logic       len_ok, crc_match;

    assign is_data = (type_q == TYPE_DATA);
    assign is_tok  = (type_q == TYPE_TOKEN);
    assign depth   = is_data ? 5'd16 : 5'd5;
    assign take    = (state_q == RECV) && s_valid && !start;
    assign head    = is_data ? dl_q[15] : dl_q[4];

    // Forwarded bit leaves the delay-line head in the same cycle the new bit arrives.
    assign d_valid = take && (is_data || is_tok) && (fill_q == depth);
    assign d_out   = d_valid & head;

    assign done    = done_q;
    assign crc_ok  = crc_ok_q;
    assign len_err = len_err_q;

    always_comb begin
        crc5_d  = crc5_q;
        crc16_d = crc16_q;
        dl_d    = dl_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        fb5     = crc5_q[4] ^ s_in;
        fb16    = crc16_q[15] ^ s_in;
        if (take) begin
            if (is_tok)
                crc5_d = {crc5_q[3:0], 1'b0} ^ (fb5 ? POLY5 : 5'd0);
            if (is_data)
                crc16_d = {crc16_q[14:0], 1'b0} ^ (fb16 ? POLY16 : 16'd0);
            dl_d = {dl_q[14:0], s_in};
            if (fill_q != depth)
                fill_d = fill_q + 5'd1;
            // A bit beyond the saturated count is remembered so overlong packets
            // cannot alias to the legal maximum length.
            if (cnt_q == CNT_SAT)
                ovf_d = 1'b1;
            else
                cnt_d = cnt_q + CW'(1);
        end
    end

    always_comb begin
        len_ok    = 1'b0;
        crc_match = 1'b0;
        case (type_q)
            TYPE_DATA: begin
                len_ok    = !ovf_d && (cnt_d >= CNT_MIN) && (cnt_d[2:0] == 3'b000);
                crc_match = (crc16_d == RES16);
            end
            TYPE_TOKEN: begin
                len_ok    = !ovf_d && (cnt_d == CNT_MIN);
                crc_match = (crc5_d == RES5);
            end
            default: begin
                len_ok    = !ovf_d && (cnt_d == '0);
                crc_match = len_ok;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            type_q    <= 2'd0;
            crc5_q    <= '0;
            crc16_q   <= '0;
            dl_q      <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            crc_ok_q  <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            crc_ok_q  <= 1'b0;
            len_err_q <= 1'b0;
            if (start) begin
                // start in any state (re)opens a packet; an aborted one never reports.
                state_q <= RECV;
                type_q  <= pkt_type;
                crc5_q  <= 5'b11111;
                crc16_q <= 16'hFFFF;
                dl_q    <= '0;
                fill_q  <= '0;
                cnt_q   <= '0;
                ovf_q   <= 1'b0;
            end else begin
                case (state_q)
                    RECV: begin
                        crc5_q  <= crc5_d;
                        crc16_q <= crc16_d;
                        dl_q    <= dl_d;
                        fill_q  <= fill_d;
                        cnt_q   <= cnt_d;
                        ovf_q   <= ovf_d;
                        if (endr) begin
                            state_q   <= STAT;
                            done_q    <= 1'b1;
                            crc_ok_q  <= len_ok && crc_match;
                            len_err_q <= !len_ok;
                        end
                    end
                    STAT:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_crc_check.sv
// Directed bench for usb_rx_crc_check: token/data/handshake packets, corruption,
// length errors, abort and asynchronous reset.
module tb_usb_rx_crc_check;

    logic       clk = 1'b0;
    logic       rst_n, s_in, s_valid, start, endr;
    logic [1:0] pkt_type;
    logic       d_out, d_valid, done, crc_ok, len_err;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int stray    = 0;
    logic out_q[$];
    logic pkt[$];

    usb_rx_crc_check #(.MAX_DATA_BYTES(8)) dut (
        .clk(clk), .rst_n(rst_n), .s_in(s_in), .s_valid(s_valid),
        .start(start), .endr(endr), .pkt_type(pkt_type),
        .d_out(d_out), .d_valid(d_valid), .done(done),
        .crc_ok(crc_ok), .len_err(len_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (d_valid === 1'b1) out_q.push_back(d_out);
            if (done === 1'b1) done_cnt++;
            if (done !== 1'b1 && (crc_ok !== 1'b0 || len_err !== 1'b0)) stray++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_lsb(input logic [15:0] v, input int w);
        for (int i = 0; i < w; i++) pkt.push_back(v[i]);
    endtask

    // CRC fields go on the wire MSB first.
    task automatic push_msb(input logic [15:0] v, input int w);
        for (int i = w - 1; i >= 0; i--) pkt.push_back(v[i]);
    endtask

    task automatic cyc(input logic st, input logic en, input logic v, input logic b);
        start = st; endr = en; s_valid = v; s_in = b;
        @(posedge clk); #1;
        start = 1'b0; endr = 1'b0; s_valid = 1'b0; s_in = 1'b0;
    endtask

    task automatic build_token();
        pkt.delete();
        push_lsb(16'h0015, 7);
        push_lsb(16'h000E, 4);
        push_msb(16'h0017, 5);
    endtask

    task automatic build_data();
        pkt.delete();
        push_lsb(16'h0000, 8);
        push_lsb(16'h0001, 8);
        push_lsb(16'h0002, 8);
        push_lsb(16'h0003, 8);
        push_msb(16'hF75E, 16);
    endtask

    // Sends nbits of pkt (gap>0 inserts an idle cycle every gap-th cycle); with fin,
    // ends the packet and checks status plus the forwarded payload.
    task automatic run_pkt(input string tag, input logic [1:0] t, input int nbits, input int gap,
                           input logic fin, input logic exp_ok, input logic exp_len);
        int n_dc, ci, n_exp, depth;
        logic [63:0] got_v, exp_v;
        out_q.delete();
        pkt_type = t;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        pkt_type = 2'd3;
        ci = 0;
        for (int i = 0; i < nbits; i++) begin
            if (gap > 0 && (ci % gap) == gap - 1) begin
                cyc(1'b0, 1'b0, 1'b0, 1'b0);
                ci++;
            end
            cyc(1'b0, 1'b0, 1'b1, pkt[i]);
            ci++;
        end
        if (fin) begin
            n_dc = done_cnt;
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            #1;
            check({tag, " done"}, done, 1'b1);
            check({tag, " crc_ok"}, crc_ok, exp_ok);
            check({tag, " len_err"}, len_err, exp_len);
            @(posedge clk); #1;
            @(negedge clk); #1;
            check({tag, " done_after"}, done, 1'b0);
            check({tag, " done_count"}, done_cnt, n_dc + 1);
            depth = (t == 2'd0) ? 16 : 5;
            n_exp = (t > 2'd1 || nbits < depth) ? 0 : nbits - depth;
            check({tag, " out_len"}, out_q.size(), n_exp);
            got_v = '0;
            exp_v = '0;
            for (int i = 0; i < out_q.size() && i < 64; i++) got_v[i] = out_q[i];
            for (int i = 0; i < n_exp && i < 64; i++) exp_v[i] = pkt[i];
            check({tag, " out_bits"}, got_v, exp_v);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int n_dc;
        rst_n = 1'b0; s_in = 1'b0; s_valid = 1'b0; start = 1'b0; endr = 1'b0; pkt_type = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {d_out, d_valid, done, crc_ok, len_err}, 5'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        build_token();
        run_pkt("token", 2'd1, 16, 0, 1'b1, 1'b1, 1'b0);

        build_data();
        run_pkt("data", 2'd0, 48, 7, 1'b1, 1'b1, 1'b0);

        build_data();
        pkt[9] = ~pkt[9];
        run_pkt("corrupt", 2'd0, 48, 0, 1'b1, 1'b0, 1'b0);

        build_token();
        run_pkt("token15", 2'd1, 15, 0, 1'b1, 1'b0, 1'b1);

        build_data();
        pkt.push_back(1'b1); pkt.push_back(1'b0); pkt.push_back(1'b1);
        run_pkt("data51", 2'd0, 51, 0, 1'b1, 1'b0, 1'b1);

        pkt.delete();
        run_pkt("hshake", 2'd2, 0, 0, 1'b1, 1'b1, 1'b0);
        pkt.delete();
        pkt.push_back(1'b1);
        run_pkt("hshake1", 2'd2, 1, 0, 1'b1, 1'b0, 1'b1);

        n_dc = done_cnt;
        build_data();
        run_pkt("abort1", 2'd0, 20, 0, 1'b0, 1'b0, 1'b0);
        check("abort partial out", out_q.size(), 4);
        run_pkt("abort2", 2'd0, 48, 0, 1'b1, 1'b1, 1'b0);
        check("abort single done", done_cnt, n_dc + 1);

        build_data();
        run_pkt("rst_pre", 2'd0, 20, 0, 1'b0, 1'b0, 1'b0);
        s_valid = 1'b1;
        s_in = pkt[20];
        #2;
        check("pre-reset d_valid", d_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async reset outputs", {d_out, d_valid, done, crc_ok, len_err}, 5'b0);
        s_valid = 1'b0;
        s_in = 1'b0;
        #2;
        rst_n = 1'b1;
        n_dc = done_cnt;
        @(posedge clk); #1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); #1;
        check("post-reset endr done", done, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("post-reset done count", done_cnt, n_dc);

        build_token();
        run_pkt("token_after_rst", 2'd1, 16, 0, 1'b1, 1'b1, 1'b0);

        check("status outside done", stray, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
